// File: rtl/sram_port_driver_pkg.sv
// Shared types and default geometry for the decoded-address SRAM port driver.
package sram_port_driver_pkg;

    localparam int unsigned RENAME_MAP_SIZE = 32;

    localparam int unsigned SRAM_INDEX_DFLT = 6;
    localparam int unsigned SRAM_DEPTH_DFLT = 64;
    localparam int unsigned SRAM_WIDTH_DFLT = 8;
    localparam int unsigned NUM_RD_DFLT     = 4;
    localparam int unsigned NUM_WR_DFLT     = 2;
    localparam int unsigned INIT_COUNT_DFLT = RENAME_MAP_SIZE;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_index_decoder.sv
// Binary index to one-hot word line decoder; all-zero output when disabled.
module sram_index_decoder
    import sram_port_driver_pkg::*;
#(
    parameter int unsigned SRAM_INDEX = SRAM_INDEX_DFLT,
    parameter int unsigned SRAM_DEPTH = SRAM_DEPTH_DFLT
) (
    input  logic                  en,
    input  logic [SRAM_INDEX-1:0] index,
    output logic [SRAM_DEPTH-1:0] onehot_c
);

    always_comb begin
        onehot_c = '0;
        if (en) begin
            onehot_c[index] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_port_driver.sv
// Driver side of the multi-ported decoded-address SRAM: registers and decodes
// requests, runs identity initialisation, forwards same-cycle writes to reads.
module sram_port_driver
    import sram_port_driver_pkg::*;
#(
    parameter int unsigned SRAM_DEPTH = SRAM_DEPTH_DFLT,
    parameter int unsigned SRAM_INDEX = SRAM_INDEX_DFLT,
    parameter int unsigned SRAM_WIDTH = SRAM_WIDTH_DFLT,
    parameter int unsigned NUM_RD     = NUM_RD_DFLT,
    parameter int unsigned NUM_WR     = NUM_WR_DFLT,
    parameter int unsigned INIT_COUNT = INIT_COUNT_DFLT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    output logic                         ready_o,
    input  logic [NUM_RD-1:0]            rd_valid_i,
    input  logic [NUM_RD*SRAM_INDEX-1:0] rd_addr_i,
    input  logic [NUM_WR-1:0]            wr_valid_i,
    input  logic [NUM_WR*SRAM_INDEX-1:0] wr_addr_i,
    input  logic [NUM_WR*SRAM_WIDTH-1:0] wr_data_i,
    output logic [NUM_RD*SRAM_DEPTH-1:0] decoded_rd_o,
    output logic [NUM_WR*SRAM_DEPTH-1:0] decoded_wr_o,
    output logic [NUM_WR-1:0]            we_o,
    output logic [NUM_WR*SRAM_WIDTH-1:0] wrdata_o,
    input  logic [NUM_RD*SRAM_WIDTH-1:0] sram_rd_data_i,
    output logic [NUM_RD-1:0]            rd_valid_o,
    output logic [NUM_RD*SRAM_WIDTH-1:0] rd_data_o,
    output logic                         wr_conflict_o
);

    state_e                  state_q, state_d, eff_state;
    logic [SRAM_INDEX-1:0]   cnt_q, cnt_d, eff_cnt;
    logic                    ready_q;
    logic                    accept;

    logic [NUM_RD-1:0]                  rd_en;
    logic [NUM_RD-1:0][SRAM_INDEX-1:0]  rd_idx;
    logic [NUM_WR-1:0]                  wr_en;
    logic [NUM_WR-1:0][SRAM_INDEX-1:0]  wr_idx;
    logic [NUM_WR-1:0][SRAM_WIDTH-1:0]  wr_dat;
    logic [NUM_RD-1:0][SRAM_DEPTH-1:0]  rd_line_c;
    logic [NUM_WR-1:0][SRAM_DEPTH-1:0]  wr_line_c;

    logic [NUM_RD-1:0][SRAM_DEPTH-1:0]  dec_rd_q;
    logic [NUM_WR-1:0][SRAM_DEPTH-1:0]  dec_wr_q;
    logic [NUM_WR-1:0]                  we_q;
    logic [NUM_WR-1:0][SRAM_WIDTH-1:0]  wrdata_q;

    logic [NUM_RD-1:0]                  rd_vld_c;
    logic [NUM_RD-1:0][SRAM_WIDTH-1:0]  rd_res_c;
    logic                               conflict_c;
    logic [NUM_RD-1:0]                  rd_valid_q;
    logic [NUM_RD-1:0][SRAM_WIDTH-1:0]  rd_data_q;
    logic                               conflict_q;

    // Flush overrides the current state so the restart takes effect this cycle.
    always_comb begin
        eff_state = state_q;
        eff_cnt   = cnt_q;
        if (flush_i) begin
            eff_state = ST_INIT;
            eff_cnt   = '0;
        end
        state_d = eff_state;
        cnt_d   = eff_cnt;
        if (eff_state == ST_INIT) begin
            cnt_d = eff_cnt + SRAM_INDEX'(1);
            if (eff_cnt == SRAM_INDEX'(INIT_COUNT - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    // Request selection: external ports in RUN, identity writes on port 0 in INIT.
    always_comb begin
        accept = ready_q & ~flush_i;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_en[k]  = accept & rd_valid_i[k];
            rd_idx[k] = rd_addr_i[k*SRAM_INDEX +: SRAM_INDEX];
        end
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            wr_en[w]  = accept & wr_valid_i[w];
            wr_idx[w] = wr_addr_i[w*SRAM_INDEX +: SRAM_INDEX];
            wr_dat[w] = wr_data_i[w*SRAM_WIDTH +: SRAM_WIDTH];
        end
        if (eff_state == ST_INIT) begin
            rd_en     = '0;
            wr_en     = '0;
            wr_en[0]  = 1'b1;
            wr_idx[0] = eff_cnt;
            wr_dat[0] = SRAM_WIDTH'(eff_cnt);
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_dec
        sram_index_decoder #(
            .SRAM_INDEX (SRAM_INDEX),
            .SRAM_DEPTH (SRAM_DEPTH)
        ) u_dec (
            .en       (rd_en[g]),
            .index    (rd_idx[g]),
            .onehot_c (rd_line_c[g])
        );
    end

    for (genvar g = 0; g < NUM_WR; g++) begin : g_wr_dec
        sram_index_decoder #(
            .SRAM_INDEX (SRAM_INDEX),
            .SRAM_DEPTH (SRAM_DEPTH)
        ) u_dec (
            .en       (wr_en[g]),
            .index    (wr_idx[g]),
            .onehot_c (wr_line_c[g])
        );
    end

    // Read result: forward from matching write lines, highest write port last.
    always_comb begin
        rd_vld_c   = '0;
        rd_res_c   = '0;
        conflict_c = 1'b0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_vld_c[k] = |dec_rd_q[k];
            rd_res_c[k] = sram_rd_data_i[k*SRAM_WIDTH +: SRAM_WIDTH];
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (|(dec_rd_q[k] & dec_wr_q[w])) begin
                    rd_res_c[k] = wrdata_q[w];
                end
            end
            if (!rd_vld_c[k]) begin
                rd_res_c[k] = '0;
            end
        end
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            for (int unsigned j = i + 1; j < NUM_WR; j++) begin
                if (|(dec_wr_q[i] & dec_wr_q[j])) begin
                    conflict_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            dec_rd_q   <= '0;
            dec_wr_q   <= '0;
            we_q       <= '0;
            wrdata_q   <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= (eff_state == ST_RUN);
            dec_rd_q   <= rd_line_c;
            dec_wr_q   <= wr_line_c;
            we_q       <= wr_en;
            wrdata_q   <= wr_dat;
            rd_valid_q <= rd_vld_c;
            rd_data_q  <= rd_res_c;
            conflict_q <= conflict_c;
        end
    end

    assign ready_o       = ready_q;
    assign decoded_rd_o  = dec_rd_q;
    assign decoded_wr_o  = dec_wr_q;
    assign we_o          = we_q;
    assign wrdata_o      = wrdata_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_data_q;
    assign wr_conflict_o = conflict_q;

endmodule

// File: tb/tb_sram_port_driver.sv
// Self-checking bench for sram_port_driver with a behavioural SRAM array model.
`timescale 1ns/1ps
module tb_sram_port_driver;

    localparam int unsigned D    = 64;
    localparam int unsigned IW   = 6;
    localparam int unsigned W    = 8;
    localparam int unsigned NR   = 4;
    localparam int unsigned NW   = 2;
    localparam int unsigned IC   = 32;
    localparam int unsigned RA_W = NR*IW;
    localparam int unsigned WA_W = NW*IW;
    localparam int unsigned WD_W = NW*W;
    localparam int unsigned RD_W = NR*W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush_i = 1'b0;
    logic              ready_o;
    logic [NR-1:0]     rd_valid_i = '0;
    logic [RA_W-1:0]   rd_addr_i = '0;
    logic [NW-1:0]     wr_valid_i = '0;
    logic [WA_W-1:0]   wr_addr_i = '0;
    logic [WD_W-1:0]   wr_data_i = '0;
    logic [NR*D-1:0]   decoded_rd_o;
    logic [NW*D-1:0]   decoded_wr_o;
    logic [NW-1:0]     we_o;
    logic [WD_W-1:0]   wrdata_o;
    logic [RD_W-1:0]   sram_rd_data;
    logic [NR-1:0]     rd_valid_o;
    logic [RD_W-1:0]   rd_data_o;
    logic              wr_conflict_o;

    typedef struct packed {
        logic [NR-1:0]   v;
        logic [RD_W-1:0] d;
        logic            c;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [W-1:0] ref_mem [D];
    logic [W-1:0] arr [D];
    logic        preload = 1'b1;
    int          n_cmp = 0;
    int          n_err = 0;

    sram_port_driver dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .ready_o        (ready_o),
        .rd_valid_i     (rd_valid_i),
        .rd_addr_i      (rd_addr_i),
        .wr_valid_i     (wr_valid_i),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .decoded_rd_o   (decoded_rd_o),
        .decoded_wr_o   (decoded_wr_o),
        .we_o           (we_o),
        .wrdata_o       (wrdata_o),
        .sram_rd_data_i (sram_rd_data),
        .rd_valid_o     (rd_valid_o),
        .rd_data_o      (rd_data_o),
        .wr_conflict_o  (wr_conflict_o)
    );

    always #5 clk = ~clk;

    // Array model: combinational read through word lines, highest write port wins.
    always_comb begin
        sram_rd_data = '0;
        for (int k = 0; k < NR; k++)
            for (int i = 0; i < D; i++)
                if (decoded_rd_o[k*D+i]) sram_rd_data[k*W +: W] = arr[i];
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < D; i++) arr[i] <= 8'hEE;
        end else begin
            for (int w = 0; w < NW; w++)
                for (int i = 0; i < D; i++)
                    if (we_o[w] && decoded_wr_o[w*D+i]) arr[i] <= wrdata_o[w*W +: W];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request cycle and push its expected read result.
    task automatic issue(input logic [NR-1:0] rv, input logic [RA_W-1:0] ra,
                         input logic [NW-1:0] wv, input logic [WA_W-1:0] wa,
                         input logic [WD_W-1:0] wd);
        exp_t         x;
        logic [IW-1:0] a;
        logic [W-1:0]  val;
        x.v = rv;
        x.d = '0;
        x.c = wv[0] & wv[1] & (wa[IW-1:0] == wa[2*IW-1:IW]);
        for (int k = 0; k < NR; k++) begin
            if (rv[k]) begin
                a   = ra[k*IW +: IW];
                val = ref_mem[a];
                for (int w = 0; w < NW; w++)
                    if (wv[w] && wa[w*IW +: IW] == a) val = wd[w*W +: W];
                x.d[k*W +: W] = val;
            end
        end
        for (int w = 0; w < NW; w++)
            if (wv[w]) ref_mem[wa[w*IW +: IW]] = wd[w*W +: W];
        sb.push_back(x);
        rd_valid_i = rv;
        rd_addr_i  = ra;
        wr_valid_i = wv;
        wr_addr_i  = wa;
        wr_data_i  = wd;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        preload = 1'b1;
        for (int i = 0; i < D; i++) ref_mem[i] = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (ready_o !== 1'b0 || we_o !== '0 || wr_conflict_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctl: ready=%b we=%b conflict=%b expected 0 00 0", ready_o, we_o, wr_conflict_o);
        end
        n_cmp++;
        if (decoded_rd_o !== '0 || decoded_wr_o !== '0) begin
            n_err++;
            $display("FAIL reset_lines: rd=%h wr=%h expected all zero", decoded_rd_o, decoded_wr_o);
        end
        n_cmp++;
        if (rd_valid_o !== '0 || rd_data_o !== '0) begin
            n_err++;
            $display("FAIL reset_rd: valid=%b data=%h expected 0 0", rd_valid_o, rd_data_o);
        end
        @(negedge clk);
        reset = 1'b1;
        preload = 1'b0;
    endtask

    task automatic test_init_seq(input string tag);
        logic [D-1:0] oh;
        for (int k = 0; k < IC; k++) begin
            tick();
            oh = '0;
            oh[k] = 1'b1;
            n_cmp++;
            if (we_o !== 2'b01 || decoded_wr_o[D-1:0] !== oh || decoded_wr_o[2*D-1:D] !== '0 ||
                wrdata_o[W-1:0] !== W'(k) || ready_o !== 1'b0 || decoded_rd_o !== '0) begin
                n_err++;
                $display("FAIL %s k=%0d: we=%b wl0=%h wd=%h ready=%b expected we=01 wl0=%h wd=%h ready=0",
                         tag, k, we_o, decoded_wr_o[D-1:0], wrdata_o[W-1:0], ready_o, oh, W'(k));
            end
            ref_mem[k] = W'(k);
        end
        tick();
        n_cmp++;
        if (ready_o !== 1'b1 || we_o !== '0) begin
            n_err++;
            $display("FAIL %s_end: ready=%b we=%b expected 1 00", tag, ready_o, we_o);
        end
    endtask

    task automatic test_read();
        logic [NR*D-1:0] exp_rd;
        exp_rd = '0;
        exp_rd[2*D+5] = 1'b1;
        issue(4'b0100, RA_W'(5) << (2*IW), '0, '0, '0);
        tick();
        n_cmp++;
        if (decoded_rd_o !== exp_rd || we_o !== '0) begin
            n_err++;
            $display("FAIL read_decode: rd=%h we=%b expected %h 00", decoded_rd_o, we_o, exp_rd);
        end
        issue('0, '0, '0, '0, '0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid_o !== e.v || rd_data_o !== e.d || rd_data_o[3*W-1:2*W] !== 8'd5) begin
            n_err++;
            $display("FAIL read_data: valid=%b data=%h expected %b %h", rd_valid_o, rd_data_o, e.v, e.d);
        end
        sb.delete();
    endtask

    task automatic test_boundary();
        issue(4'b1111, {6'd63, 6'd0, 6'd31, 6'd32}, '0, '0, '0);
        tick();
        issue('0, '0, '0, '0, '0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid_o !== e.v || rd_data_o !== e.d || rd_data_o !== 32'hEE001FEE) begin
            n_err++;
            $display("FAIL boundary: valid=%b data=%h expected %b %h", rd_valid_o, rd_data_o, e.v, e.d);
        end
        sb.delete();
    endtask

    task automatic test_forwarding();
        issue(4'b0001, RA_W'(7), 2'b10, WA_W'(7) << IW, WD_W'(8'hA5) << W);
        tick();
        issue('0, '0, '0, '0, '0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid_o !== e.v || rd_data_o !== e.d || rd_data_o[W-1:0] !== 8'hA5) begin
            n_err++;
            $display("FAIL forwarding: valid=%b data=%h expected %b %h", rd_valid_o, rd_data_o, e.v, e.d);
        end
        sb.delete();
    endtask

    task automatic test_conflict();
        logic [D-1:0] oh;
        oh = '0;
        oh[9] = 1'b1;
        issue('0, '0, 2'b11, {6'd9, 6'd9}, {8'h22, 8'h11});
        tick();
        n_cmp++;
        if (we_o !== 2'b11 || decoded_wr_o !== {oh, oh} || wr_conflict_o !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_drive: we=%b wl=%h conflict=%b expected 11 both bit9 0", we_o, decoded_wr_o, wr_conflict_o);
        end
        issue(4'b0001, RA_W'(9), '0, '0, '0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (wr_conflict_o !== e.c || wr_conflict_o !== 1'b1 || rd_valid_o !== e.v) begin
            n_err++;
            $display("FAIL conflict_pulse: conflict=%b valid=%b expected %b %b", wr_conflict_o, rd_valid_o, e.c, e.v);
        end
        issue('0, '0, '0, '0, '0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (rd_data_o !== e.d || rd_data_o[W-1:0] !== 8'h22 || wr_conflict_o !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_read: data=%h conflict=%b expected %h 0", rd_data_o, wr_conflict_o, e.d);
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 42; i++) begin
            if (i < 40)
                issue(NR'($urandom), RA_W'($urandom), NW'($urandom), WA_W'($urandom), WD_W'($urandom));
            else
                issue('0, '0, '0, '0, '0);
            tick();
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                n_cmp++;
                if (rd_valid_o !== e.v || rd_data_o !== e.d || wr_conflict_o !== e.c) begin
                    n_err++;
                    $display("FAIL b2b i=%0d: valid=%b data=%h conflict=%b expected %b %h %b",
                             i, rd_valid_o, rd_data_o, wr_conflict_o, e.v, e.d, e.c);
                end
            end
        end
        sb.delete();
        rd_valid_i = '0;
        wr_valid_i = '0;
    endtask

    task automatic test_flush();
        logic [D-1:0] oh;
        rd_valid_i = 4'b0001;
        rd_addr_i  = RA_W'(2);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        rd_valid_i = '0;
        n_cmp++;
        if (decoded_rd_o !== '0 || ready_o !== 1'b0 || we_o !== 2'b01 || wrdata_o[W-1:0] !== 8'd0) begin
            n_err++;
            $display("FAIL flush_run: rd=%h ready=%b we=%b wd=%h expected 0 0 01 00", decoded_rd_o, ready_o, we_o, wrdata_o[W-1:0]);
        end
        for (int k = 1; k < 10; k++) tick();
        n_cmp++;
        if (wrdata_o[W-1:0] !== 8'd9) begin
            n_err++;
            $display("FAIL flush_pre: wd=%h expected 09", wrdata_o[W-1:0]);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_cmp++;
        if (wrdata_o[W-1:0] !== 8'd0 || decoded_wr_o[D-1:0] !== 64'd1 || we_o !== 2'b01) begin
            n_err++;
            $display("FAIL flush_restart: wd=%h wl0=%h we=%b expected 00 1 01", wrdata_o[W-1:0], decoded_wr_o[D-1:0], we_o);
        end
        for (int k = 1; k < IC; k++) begin
            tick();
            oh = '0;
            oh[k] = 1'b1;
            n_cmp++;
            if (wrdata_o[W-1:0] !== W'(k) || decoded_wr_o[D-1:0] !== oh || ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL flush_seq k=%0d: wd=%h wl0=%h ready=%b expected %h %h 0",
                         k, wrdata_o[W-1:0], decoded_wr_o[D-1:0], ready_o, W'(k), oh);
            end
        end
        tick();
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_ready: ready=%b expected 1 at 32 cycles", ready_o);
        end
        for (int k = 0; k < IC; k++) ref_mem[k] = W'(k);
    endtask

    task automatic test_async_reset();
        issue(4'b0010, RA_W'(3) << IW, '0, '0, '0);
        tick();
        issue(4'b0001, RA_W'(4), '0, '0, '0);
        tick();
        rd_valid_i = '0;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (ready_o !== 1'b0 || rd_valid_o !== '0 || rd_data_o !== '0 || decoded_rd_o !== '0 ||
            decoded_wr_o !== '0 || we_o !== '0 || wr_conflict_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: ready=%b valid=%b data=%h rd=%h we=%b expected all zero",
                     ready_o, rd_valid_o, rd_data_o, decoded_rd_o, we_o);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        test_init_seq("reinit");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t limit=500000", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init_seq("init");
        test_read();
        test_boundary();
        test_forwarding();
        test_conflict();
        test_back_to_back();
        test_flush();
        test_read();
        test_async_reset();
        test_forwarding();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
